// File: rtl/piso_pkg.sv
// Shared state encoding and helpers for the piso_stream serialiser.
package piso_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    PARITY = ST_PARITY
  } state_t;

  // A counter needs at least one bit, even for a degenerate word width.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit index counter for piso_stream: clear on word capture, advance per shifted bit,
// terminal count flags the final data bit.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_tc = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_stream.sv
// Parallel-in serial-out streamer with valid/ready load handshake and hold control.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_stream
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam logic MSB = (MSB_FIRST != 0);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_n;
  logic             r_sout;
  logic             w_sout_n;
  logic             w_tc;
  logic             w_last;
  logic             w_ready;
  logic             w_xfer;
  logic             w_advance;
`ifdef PISO_PARITY_EN
  logic             r_par;
`endif

`ifdef PISO_PARITY_EN
  assign w_last = (r_state == PARITY);
`else
  assign w_last = (r_state == SHIFT) && w_tc;
`endif

  // A new word may enter while the last bit of the previous one leaves.
  assign w_ready   = (r_state == IDLE) || (w_last && shift_en);
  assign w_xfer    = load_valid && w_ready;
  assign w_advance = shift_en && (r_state == SHIFT) && !w_tc;

  piso_bit_cnt #(
    .WIDTH(WIDTH)
  ) u_bit_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_xfer),
    .i_enable(w_advance),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_sout_n  = r_sout;
    w_shreg_n = r_shreg;
    if (w_xfer) begin
      w_next    = SHIFT;
      w_sout_n  = MSB ? load_data[WIDTH-1] : load_data[0];
      w_shreg_n = MSB ? (load_data << 1) : (load_data >> 1);
    end else if (shift_en) begin
      case (r_state)
        SHIFT: begin
          if (!w_tc) begin
            w_sout_n  = MSB ? r_shreg[WIDTH-1] : r_shreg[0];
            w_shreg_n = MSB ? (r_shreg << 1) : (r_shreg >> 1);
          end else begin
`ifdef PISO_PARITY_EN
            w_next   = PARITY;
            w_sout_n = r_par;
`else
            w_next   = IDLE;
            w_sout_n = 1'b0;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          w_next   = IDLE;
          w_sout_n = 1'b0;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sout  <= 1'b0;
      r_shreg <= '0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_sout  <= w_sout_n;
      r_shreg <= w_shreg_n;
`ifdef PISO_PARITY_EN
      if (w_xfer) begin
        r_par <= ^load_data;
      end
`endif
    end
  end

  assign load_ready = w_ready;
  assign sout       = r_sout;
  assign sout_valid = (r_state != IDLE);
  assign sout_last  = w_last;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_piso_stream.sv
// Directed self-checking bench for piso_stream: one LSB-first and one MSB-first instance.
// Parity expectations follow when PISO_PARITY_EN is defined.
module tb_piso_stream;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int SL = 8 + PAR;

  logic       clk;
  logic       rst;
  logic       shiftEn;
  logic       loadValid, loadReady, sout, soutValid, soutLast, busy;
  logic [7:0] loadData;
  logic       mLoadValid, mLoadReady, mSout, mSoutValid, mSoutLast, mBusy;
  logic [7:0] mLoadData;

  int nAsserts = 0;
  int nFails   = 0;

  piso_stream #(.WIDTH(8), .MSB_FIRST(0)) dut (
    .clk(clk), .rst(rst), .load_valid(loadValid), .load_ready(loadReady),
    .load_data(loadData), .shift_en(shiftEn), .sout(sout),
    .sout_valid(soutValid), .sout_last(soutLast), .busy(busy)
  );

  piso_stream #(.WIDTH(8), .MSB_FIRST(1)) dutMsb (
    .clk(clk), .rst(rst), .load_valid(mLoadValid), .load_ready(mLoadReady),
    .load_data(mLoadData), .shift_en(shiftEn), .sout(mSout),
    .sout_valid(mSoutValid), .sout_last(mSoutLast), .busy(mBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic expBit(input logic [7:0] w, input int i, input bit msb);
    if (i >= 8) return ^w;
    return msb ? w[7-i] : w[i];
  endfunction

  // Full word on the LSB-first instance, starting from IDLE.
  task automatic applyStimulus(input logic [7:0] w, input string tag);
    loadValid = 1'b1;
    loadData  = w;
    checkOutput({tag, "_ready"}, loadReady, 1);
    tick;
    loadValid = 1'b0;
    for (int i = 0; i < SL; i++) begin
      checkOutput({tag, "_sout"}, sout, expBit(w, i, 1'b0));
      checkOutput({tag, "_valid"}, soutValid, 1);
      checkOutput({tag, "_last"}, soutLast, (i == SL - 1));
      tick;
    end
    checkOutput({tag, "_idleBusy"}, busy, 0);
    checkOutput({tag, "_idleValid"}, soutValid, 0);
    checkOutput({tag, "_idleSout"}, sout, 0);
  endtask

  task automatic streamMsb(input logic [7:0] w, input string tag);
    mLoadValid = 1'b1;
    mLoadData  = w;
    checkOutput({tag, "_ready"}, mLoadReady, 1);
    tick;
    mLoadValid = 1'b0;
    for (int i = 0; i < SL; i++) begin
      checkOutput({tag, "_sout"}, mSout, expBit(w, i, 1'b1));
      checkOutput({tag, "_valid"}, mSoutValid, 1);
      checkOutput({tag, "_last"}, mSoutLast, (i == SL - 1));
      tick;
    end
    checkOutput({tag, "_idleBusy"}, mBusy, 0);
  endtask

  initial begin
    rst        = 1'b0;
    shiftEn    = 1'b1;
    loadValid  = 1'b0;
    loadData   = 8'h00;
    mLoadValid = 1'b0;
    mLoadData  = 8'h00;
    tick;
    tick;

    $display("[TB] reset state");
    checkOutput("rstSout", sout, 0);
    checkOutput("rstValid", soutValid, 0);
    checkOutput("rstLast", soutLast, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstMsbBusy", mBusy, 0);
    rst = 1'b1;
    tick;
    checkOutput("postRstReady", loadReady, 1);

    $display("[TB] single word 0xA5 LSB first");
    applyStimulus(8'hA5, "a5");

    $display("[TB] MSB first 0x80 and 0x01");
    streamMsb(8'h80, "msb80");
    streamMsb(8'h01, "msb01");

    $display("[TB] load while busy is ignored");
    loadValid = 1'b1;
    loadData  = 8'h0F;
    tick;
    loadData = 8'h00;
    checkOutput("ign_ready", loadReady, 0);
    checkOutput("ign_sout1", sout, 1);
    tick;
    loadValid = 1'b0;
    for (int c = 2; c <= SL; c++) begin
      checkOutput("ign_sout", sout, expBit(8'h0F, c - 1, 1'b0));
      checkOutput("ign_last", soutLast, (c == SL));
      tick;
    end
    checkOutput("ign_busy", busy, 0);

    $display("[TB] back-to-back 0x0F then 0xF0");
    loadValid = 1'b1;
    loadData  = 8'h0F;
    checkOutput("b2b_ready0", loadReady, 1);
    tick;
    loadData = 8'hF0;
    for (int k = 1; k <= 2 * SL; k++) begin
      if (k == SL + 1) loadValid = 1'b0;
      checkOutput("b2b_sout", sout,
                  (k <= SL) ? expBit(8'h0F, k - 1, 1'b0) : expBit(8'hF0, k - SL - 1, 1'b0));
      checkOutput("b2b_valid", soutValid, 1);
      if (k < 2 * SL) checkOutput("b2b_ready", loadReady, (k == SL));
      checkOutput("b2b_last", soutLast, (k == SL) || (k == 2 * SL));
      tick;
    end
    checkOutput("b2b_busy", busy, 0);

    $display("[TB] shift_en hold on 0xFF");
    loadValid = 1'b1;
    loadData  = 8'hFF;
    tick;
    loadValid = 1'b0;
    tick;
    shiftEn = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      tick;
      checkOutput("hold_sout", sout, 1);
      checkOutput("hold_valid", soutValid, 1);
      checkOutput("hold_last", soutLast, 0);
      checkOutput("hold_ready", loadReady, 0);
    end
    shiftEn = 1'b1;
    for (int c = 6; c <= 11 + PAR; c++) begin
      tick;
      checkOutput("hold_rsout", sout, expBit(8'hFF, c - 4, 1'b0));
      checkOutput("hold_rlast", soutLast, (c == 11 + PAR));
    end
    tick;
    checkOutput("hold_busy", busy, 0);

    $display("[TB] reset mid-word on 0x3C");
    loadValid = 1'b1;
    loadData  = 8'h3C;
    tick;
    loadValid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checkOutput("mid_sout", sout, expBit(8'h3C, c - 1, 1'b0));
      if (c < 4) tick;
    end
    rst = 1'b0;
    tick;
    checkOutput("mid_rstSout", sout, 0);
    checkOutput("mid_rstValid", soutValid, 0);
    checkOutput("mid_rstLast", soutLast, 0);
    checkOutput("mid_rstBusy", busy, 0);
    rst = 1'b1;
    tick;
    applyStimulus(8'h81, "post81");

    $display("[TB] reset beats concurrent load");
    rst       = 1'b0;
    loadValid = 1'b1;
    loadData  = 8'hFF;
    tick;
    checkOutput("pri_valid", soutValid, 0);
    checkOutput("pri_busy", busy, 0);
    rst       = 1'b1;
    loadValid = 1'b0;
    tick;
    checkOutput("pri_valid2", soutValid, 0);
    checkOutput("pri_sout2", sout, 0);

`ifdef PISO_PARITY_EN
    $display("[TB] parity words 0x07 and 0x03");
    applyStimulus(8'h07, "par07");
    applyStimulus(8'h03, "par03");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/piso_stream.md
PISO_STREAM -- requirements
Module: piso_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, parallel word width in bits (>= 2).
REQ-002 SHALL have parameter MSB_FIRST, default 0, 1 = shift MSB first, 0 = shift LSB first.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port load_valid  input  1  parallel word offered.
REQ-006 SHALL have port load_ready  output  1  block accepts word this cycle.
REQ-007 SHALL have port load_data  input  WIDTH  parallel word.
REQ-008 SHALL have port shift_en  input  1  advance serial stream; low = hold.
REQ-009 SHALL have port sout  output  1  serial data, registered.
REQ-010 SHALL have port sout_valid  output  1  sout carries a stream bit.
REQ-011 SHALL have port sout_last  output  1  sout is final bit of the current word.
REQ-012 SHALL have port busy  output  1  word in flight (state != IDLE).

Function
REQ-013 SHALL implement states IDLE, SHIFT, plus PARITY when PISO_PARITY_EN is defined.
REQ-014 Transfer SHALL occur when load_valid && load_ready; load_data is captured into the shift register and the bit counter is cleared.
REQ-015 load_ready SHALL be 1 in IDLE, and 1 in SHIFT/PARITY only when sout_last && shift_en; else 0.
REQ-016 The first bit SHALL appear on sout with sout_valid=1 one clock after the transfer cycle (latency 1).
REQ-017 Bit order SHALL be load_data[0] first when MSB_FIRST=0, load_data[WIDTH-1] first when MSB_FIRST=1.
REQ-018 In SHIFT with shift_en=1, the next bit SHALL be presented each clock; with shift_en=0, sout/sout_valid/sout_last/counter SHALL hold.
REQ-019 Bit counter SHALL be $clog2(WIDTH) bits wide; sout_last SHALL be 1 exactly when the final bit (data bit WIDTH-1, or the parity bit) is on sout.
REQ-020 On final bit with shift_en=1: a concurrent transfer SHALL present the new word's first bit next cycle with no gap; otherwise the block SHALL go to IDLE.
REQ-021 In IDLE, sout, sout_valid, sout_last SHALL be 0; load_valid while busy and not ready SHALL be ignored (no capture).

Reset
REQ-022 On rst=0 at a rising clk edge: state=IDLE, shift register=0, counter=0, sout=0, sout_valid=0, sout_last=0, busy=0; load_ready=1 from the first cycle after reset deasserts.
REQ-023 Reset mid-word SHALL discard the remaining bits; no partial-word continuation.
REQ-024 Reset SHALL take priority over a concurrent transfer.

Configuration
REQ-025 Macro PISO_PARITY_EN: when defined, one even-parity bit (XOR of the captured word) SHALL follow the data bits in state PARITY, carrying sout_last; stream = WIDTH+1 bits.
REQ-026 Without PISO_PARITY_EN: no PARITY state, stream = WIDTH bits, sout_last on data bit WIDTH-1.

Structure
REQ-027 A shared package piso_pkg SHALL hold the state enum typedef (IDLE, SHIFT, PARITY) and state-encoding constants.
REQ-028 The bit counter SHALL be a sub-module piso_bit_cnt (clear, enable, terminal-count output) parametrised by WIDTH.

Verification
REQ-029 WIDTH=8, MSB_FIRST=0, shift_en=1, load 0xA5 -> sout 1,0,1,0,0,1,0,1 on cycles 1..8 after transfer, sout_last only at cycle 8, busy=0 at cycle 9.
REQ-030 MSB_FIRST=1, load 0x80 -> first sout=1 then seven 0s; load 0x01 -> seven 0s then 1 with sout_last.
REQ-031 Back-to-back 0x0F then 0xF0, load_valid held -> 16 contiguous valid bits 1111 0000 0000 1111 (LSB first), no idle cycle, load_ready=1 on cycles 0 and 8 only.
REQ-032 Load 0xFF, drop shift_en for 3 cycles after bit 2 -> sout/sout_last/counter frozen; stream resumes with 6 remaining bits, total 11 cycles.
REQ-033 Assert rst=0 after bit 4 of 0x3C -> next cycle all outputs 0, state IDLE; new load 0x81 streams cleanly from bit 0.
REQ-034 PISO_PARITY_EN defined, load 0x07 -> 8 data bits then parity bit 1 with sout_last=1 on cycle 9; load 0x03 -> parity bit 0.
